mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single read port of the data bsram between the CPU (single-word loads) and the GPU fetch unit (burst reads of rectangle/attribute tables).
- Sits between both requesters and the bsram read address/data pins; the bsram write port stays wired directly to the CPU.
- Performs round-robin arbitration per transaction, generates burst addresses, and tracks the bsram's 1-cycle read latency to return tagged valid strobes.

Parameters:
- DATA_WIDTH, 13, data memory address width
- BURST_LEN_W, 4, width of gpu_burst_len; burst length range is 1..2^BURST_LEN_W

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU read request; held with cpu_addr until cpu_gnt
- cpu_addr  input  DATA_WIDTH  CPU read address
- cpu_gnt  output  1  one-cycle pulse: CPU request accepted
- cpu_rvalid  output  1  rdata valid for CPU
- gpu_req  input  1  GPU burst request; held with gpu_addr/gpu_burst_len until gpu_gnt
- gpu_addr  input  DATA_WIDTH  burst start address
- gpu_burst_len  input  BURST_LEN_W  beat count; 0 encodes 2^BURST_LEN_W
- gpu_gnt  output  1  one-cycle pulse: GPU burst accepted
- gpu_rvalid  output  1  rdata valid for GPU, one per beat
- gpu_rlast  output  1  qualifies the final GPU beat
- mem_addr  output  DATA_WIDTH  to bsram mem_dout_addr (registered)
- mem_rdata  input  16  from bsram mem_dout
- rdata  output  16  mem_rdata forwarded combinationally to both requesters

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - mem_addr, gnt, rvalid and rlast outputs all go to 0.
  - rr_last_gpu goes to 0, so the GPU wins the first tie.
  - Beat counter goes to 0.
  - Any in-flight read is discarded; no rvalid is issued after reset releases for a pre-reset read.
- States:
  - IDLE: no read issued.
  - CPU_RD: exactly 1 cycle; mem_addr = latched cpu_addr; next state is IDLE.
  - GPU_BURST: one address per cycle, addr, addr+1, ...; stays for N cycles (N = decoded length); next state is IDLE.
- Arbitration (IDLE only; evaluated on the clock edge):
  - Only one requester asserted: that requester wins.
  - Both asserted: the requester that did not win last time wins. rr_last_gpu updates on every grant.
- Grant timing, CPU request sampled at edge E:
  - After E: state = CPU_RD, mem_addr = cpu_addr, cpu_gnt = 1 for that one cycle.
  - bsram samples mem_addr at E+1; cpu_rvalid = 1 for the cycle after E+1.
- Grant timing, GPU request sampled at edge E:
  - After E: gpu_gnt pulses for 1 cycle.
  - mem_addr steps through start .. start+N-1 on consecutive cycles.
  - gpu_rvalid trails each address by one cycle; gpu_rlast accompanies the Nth rvalid.
- Back-to-back: the state returns to IDLE for at least 1 cycle between transactions. The rvalid of the previous transaction may overlap the next grant cycle.
- Address arithmetic: burst address increments modulo 2^DATA_WIDTH (0x1FFF+1 wraps to 0x0000).
- Latency tracking: a 2-bit registered tag {cpu, gpu} plus a last flag delays the "read issued" indication by one cycle to produce the rvalid/rlast outputs.
- Signal quality: gnt, rvalid and rlast are never asserted simultaneously for both requesters. rdata is don't-care when neither rvalid is set.
- Request withdrawal: a request dropped before its grant is simply not served.

Optional Feature:
- Macro: GPU_STRICT_PRIO_EN.
- Defined:
  - The GPU wins every tie in IDLE, and rr_last_gpu is unused.
  - The GPU never waits behind the CPU (display deadline). The CPU may starve during continuous GPU requests.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- CPU only:
  - Stimulus: bsram[0x0010]=0xBEEF; cpu_req with cpu_addr=0x0010 sampled at edge E.
  - Response: cpu_gnt high after E; cpu_rvalid high with rdata=0xBEEF after E+1; gpu outputs stay 0.
- GPU burst:
  - Stimulus: gpu_addr=0x0100, gpu_burst_len=3, bsram[0x100..0x102]=1,2,3.
  - Response: mem_addr=0x100,0x101,0x102 on consecutive cycles; gpu_rvalid for 3 cycles with rdata 1,2,3; gpu_rlast on the third beat only.
- Wrap and max length:
  - Stimulus: gpu_addr=0x1FFE, gpu_burst_len=0.
  - Response: 16 beats, addresses 0x1FFE,0x1FFF,0x0000..0x000D; rlast on beat 16.
- Contention:
  - Stimulus: cpu_req and gpu_req held high continuously.
  - Response: grants alternate GPU, CPU, GPU, CPU, GPU first after reset.
  - Response with GPU_STRICT_PRIO_EN defined: only gpu_gnt is issued.
- Reset mid-burst:
  - Stimulus: drop reset on the 2nd beat of a len=8 burst, then release it.
  - Response: all outputs 0 immediately; no further gpu_rvalid; the next request is served from IDLE normally.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the bsram read port between CPU single-word loads
// and GPU bursts. Define GPU_STRICT_PRIO_EN to make the GPU win every tie.
module mem_read_arbiter #(
  parameter int DATA_WIDTH  = 13,
  parameter int BURST_LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [DATA_WIDTH-1:0]  cpu_addr,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  input  logic                   gpu_req,
  input  logic [DATA_WIDTH-1:0]  gpu_addr,
  input  logic [BURST_LEN_W-1:0] gpu_burst_len,
  output logic                   gpu_gnt,
  output logic                   gpu_rvalid,
  output logic                   gpu_rlast,
  output logic [DATA_WIDTH-1:0]  mem_addr,
  input  logic [15:0]            mem_rdata,
  output logic [15:0]            rdata
);

  localparam logic [BURST_LEN_W-1:0] BEAT_ONE = BURST_LEN_W'(1);
  localparam logic [DATA_WIDTH-1:0]  ADDR_ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_RD    = 2'd1,
    GPU_BURST = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  mem_addr_reg, mem_addr_next;
  logic [BURST_LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic                   cpu_gnt_reg, cpu_gnt_next;
  logic                   gpu_gnt_reg, gpu_gnt_next;
  logic                   cpu_tag_reg, gpu_tag_reg, last_reg;
  logic                   grant_cpu, grant_gpu;
`ifndef GPU_STRICT_PRIO_EN
  logic                   rr_last_gpu_reg, rr_last_gpu_next;
`endif

  // Requests are only looked at while the read port is idle.
  always_comb begin
    grant_cpu = 1'b0;
    grant_gpu = 1'b0;
    if (state_reg == IDLE) begin
`ifdef GPU_STRICT_PRIO_EN
      grant_gpu = gpu_req;
      grant_cpu = cpu_req && !gpu_req;
`else
      if (cpu_req && gpu_req) begin
        grant_gpu = !rr_last_gpu_reg;
        grant_cpu = rr_last_gpu_reg;
      end else begin
        grant_gpu = gpu_req;
        grant_cpu = cpu_req;
      end
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    beat_cnt_next = beat_cnt_reg;
    cpu_gnt_next  = 1'b0;
    gpu_gnt_next  = 1'b0;
`ifndef GPU_STRICT_PRIO_EN
    rr_last_gpu_next = rr_last_gpu_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_gpu) begin
          state_next    = GPU_BURST;
          mem_addr_next = gpu_addr;
          // Length 0 encodes the maximum burst; the subtraction wraps to it.
          beat_cnt_next = gpu_burst_len - BEAT_ONE;
          gpu_gnt_next  = 1'b1;
`ifndef GPU_STRICT_PRIO_EN
          rr_last_gpu_next = 1'b1;
`endif
        end else if (grant_cpu) begin
          state_next    = CPU_RD;
          mem_addr_next = cpu_addr;
          cpu_gnt_next  = 1'b1;
`ifndef GPU_STRICT_PRIO_EN
          rr_last_gpu_next = 1'b0;
`endif
        end
      end
      CPU_RD: state_next = IDLE;
      GPU_BURST: begin
        if (beat_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          mem_addr_next = mem_addr_reg + ADDR_ONE;
          beat_cnt_next = beat_cnt_reg - BEAT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mem_addr_reg <= '0;
      beat_cnt_reg <= '0;
      cpu_gnt_reg  <= 1'b0;
      gpu_gnt_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      beat_cnt_reg <= beat_cnt_next;
      cpu_gnt_reg  <= cpu_gnt_next;
      gpu_gnt_reg  <= gpu_gnt_next;
    end
  end

`ifndef GPU_STRICT_PRIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_last_gpu_reg <= 1'b0;
    else        rr_last_gpu_reg <= rr_last_gpu_next;
  end
`endif

  // The address issued this cycle returns from the bsram one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_tag_reg <= 1'b0;
      gpu_tag_reg <= 1'b0;
      last_reg    <= 1'b0;
    end else begin
      cpu_tag_reg <= (state_reg == CPU_RD);
      gpu_tag_reg <= (state_reg == GPU_BURST);
      last_reg    <= (state_reg == GPU_BURST) && (beat_cnt_reg == '0);
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign cpu_gnt    = cpu_gnt_reg;
  assign gpu_gnt    = gpu_gnt_reg;
  assign cpu_rvalid = cpu_tag_reg;
  assign gpu_rvalid = gpu_tag_reg;
  assign gpu_rlast  = last_reg;
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: a cycle-indexed expectation timeline is
// filled from the arbitration/burst rules at each grant and compared every cycle.
module tb_mem_read_arbiter;
  localparam int AW = 13;
  localparam int LW = 4;
  localparam int NC = 4096;
  localparam int MEM_WORDS = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic          gpu_req = 1'b0;
  logic [AW-1:0] gpu_addr = '0;
  logic [LW-1:0] gpu_burst_len = '0;
  logic          gpu_gnt, gpu_rvalid, gpu_rlast;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata = '0;
  logic [15:0]   rdata;

  mem_read_arbiter #(.DATA_WIDTH(AW), .BURST_LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_burst_len(gpu_burst_len),
    .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rlast(gpu_rlast),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // bsram read port: registered read of the sampled address.
  logic [15:0] mem [MEM_WORDS];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_err = 0;
  int k = 0;
  int free_at = 0;
  bit rr_last_gpu = 1'b0;
  int last_gpu_gnt_k = -1;

  bit          e_cpu_gnt [NC];
  bit          e_gpu_gnt [NC];
  bit          e_cpu_rv  [NC];
  bit          e_gpu_rv  [NC];
  bit          e_rlast   [NC];
  bit          e_addr_v  [NC];
  logic [AW-1:0] e_addr  [NC];
  logic [15:0] e_data    [NC];

  bit          cpu_pend = 1'b0;
  logic [AW-1:0] cpu_pend_addr = '0;
  bit          gpu_pend = 1'b0;
  logic [AW-1:0] gpu_pend_addr = '0;
  logic [LW-1:0] gpu_pend_len = '0;
  bit          rand_mode = 1'b0;
  bit          cont_mode = 1'b0;
  bit          rec_order = 1'b0;
  bit          order_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d: got %0h want %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      e_cpu_gnt[i] = 1'b0; e_gpu_gnt[i] = 1'b0; e_cpu_rv[i] = 1'b0;
      e_gpu_rv[i] = 1'b0; e_rlast[i] = 1'b0; e_addr_v[i] = 1'b0;
      e_addr[i] = '0; e_data[i] = '0;
    end
    k = 0;
    free_at = 0;
    rr_last_gpu = 1'b0;
    cpu_pend = 1'b0;
    gpu_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cpu_gnt"}, cpu_gnt, 0);
    check_eq({tag, "_gpu_gnt"}, gpu_gnt, 0);
    check_eq({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    check_eq({tag, "_gpu_rvalid"}, gpu_rvalid, 0);
    check_eq({tag, "_gpu_rlast"}, gpu_rlast, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  // Decide the winner at the coming edge (k+1) and lay out its whole timeline.
  task automatic model_edge();
    bit win_gpu, win_cpu;
    int e, n;
    if (k + 1 < free_at) return;
    e = k + 1;
`ifdef GPU_STRICT_PRIO_EN
    win_gpu = gpu_pend;
`else
    win_gpu = gpu_pend && (!cpu_pend || !rr_last_gpu);
`endif
    win_cpu = cpu_pend && !win_gpu;
    if (win_gpu) begin
      n = (gpu_pend_len == 0) ? (1 << LW) : int'(gpu_pend_len);
      e_gpu_gnt[e] = 1'b1;
      for (int i = 0; i < n; i++) begin
        e_addr_v[e + i] = 1'b1;
        e_addr[e + i]   = AW'((int'(gpu_pend_addr) + i) % MEM_WORDS);
        e_gpu_rv[e + i + 1] = 1'b1;
        e_data[e + i + 1]   = mem[(int'(gpu_pend_addr) + i) % MEM_WORDS];
      end
      e_rlast[e + n] = 1'b1;
      free_at = e + n + 1;
      rr_last_gpu = 1'b1;
      gpu_pend = 1'b0;
      last_gpu_gnt_k = e;
      $display("txn cycle=%0d gpu burst addr=%04h beats=%0d", e, gpu_pend_addr, n);
    end else if (win_cpu) begin
      e_cpu_gnt[e] = 1'b1;
      e_addr_v[e]  = 1'b1;
      e_addr[e]    = cpu_pend_addr;
      e_cpu_rv[e + 1] = 1'b1;
      e_data[e + 1]   = mem[cpu_pend_addr];
      free_at = e + 2;
      rr_last_gpu = 1'b0;
      cpu_pend = 1'b0;
      $display("txn cycle=%0d cpu read addr=%04h", e, cpu_pend_addr);
    end
  endtask

  task automatic new_gpu_req();
    gpu_pend = 1'b1;
    gpu_pend_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(8176, 8191))
                                                 : AW'($urandom_range(0, MEM_WORDS - 1));
    gpu_pend_len = LW'($urandom_range(0, 15));
  endtask

  task automatic new_cpu_req();
    cpu_pend = 1'b1;
    cpu_pend_addr = AW'($urandom_range(0, MEM_WORDS - 1));
  endtask

  // Called at a falling edge: check cycle k, drive inputs, predict edge k+1.
  task automatic step();
    check_eq("cpu_gnt", cpu_gnt, e_cpu_gnt[k]);
    check_eq("gpu_gnt", gpu_gnt, e_gpu_gnt[k]);
    check_eq("cpu_rvalid", cpu_rvalid, e_cpu_rv[k]);
    check_eq("gpu_rvalid", gpu_rvalid, e_gpu_rv[k]);
    check_eq("gpu_rlast", gpu_rlast, e_rlast[k]);
    if (e_addr_v[k]) check_eq("mem_addr", mem_addr, e_addr[k]);
    if (e_cpu_rv[k] || e_gpu_rv[k]) check_eq("rdata", rdata, e_data[k]);
    if (rec_order && (cpu_gnt || gpu_gnt)) order_q.push_back(gpu_gnt);

    if (cont_mode) begin
      if (!cpu_pend) new_cpu_req();
      if (!gpu_pend) new_gpu_req();
    end else if (rand_mode) begin
      if (cpu_pend && $urandom_range(0, 15) == 0) cpu_pend = 1'b0;
      else if (!cpu_pend && $urandom_range(0, 3) == 0) new_cpu_req();
      if (gpu_pend && $urandom_range(0, 15) == 0) gpu_pend = 1'b0;
      else if (!gpu_pend && $urandom_range(0, 5) == 0) new_gpu_req();
    end
    cpu_req = cpu_pend;
    cpu_addr = cpu_pend_addr;
    gpu_req = gpu_pend;
    gpu_addr = gpu_pend_addr;
    gpu_burst_len = gpu_pend_len;

    model_edge();
    k++;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((cpu_pend || gpu_pend || k <= free_at) && n < limit) begin
      step();
      n++;
    end
    check_eq("drain_done", (n < limit), 1);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0100] = 16'h0001;
    mem[16'h0101] = 16'h0002;
    mem[16'h0102] = 16'h0003;
    model_reset();

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Contention straight out of reset.
    rec_order = 1'b1;
    cont_mode = 1'b1;
    for (int i = 0; i < 400 && order_q.size() < 5; i++) step();
    cont_mode = 1'b0;
    rec_order = 1'b0;
    check_eq("order_count", (order_q.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order_q.size(); i++) begin
`ifdef GPU_STRICT_PRIO_EN
      check_eq("order_gpu_only", order_q[i], 1);
`else
      check_eq("order_alternate", order_q[i], ((i % 2) == 0) ? 1 : 0);
`endif
    end
    drain(300);

    // CPU only.
    cpu_pend = 1'b1; cpu_pend_addr = 13'h0010;
    drain(20);

    // Short GPU burst.
    gpu_pend = 1'b1; gpu_pend_addr = 13'h0100; gpu_pend_len = 4'd3;
    drain(20);

    // Wrap and maximum length.
    gpu_pend = 1'b1; gpu_pend_addr = 13'h1FFE; gpu_pend_len = 4'd0;
    drain(40);

    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) step();
    rand_mode = 1'b0;
    drain(300);

    // Reset during the second beat of a len=8 burst.
    last_gpu_gnt_k = -1;
    gpu_pend = 1'b1; gpu_pend_addr = AW'($urandom_range(0, MEM_WORDS - 1)); gpu_pend_len = 4'd8;
    for (int i = 0; i < 20 && !(last_gpu_gnt_k >= 0 && k == last_gpu_gnt_k + 2); i++) step();
    check_eq("rst_reached_beat2", (last_gpu_gnt_k >= 0 && k == last_gpu_gnt_k + 2), 1);
    check_eq("rst_beat2_rvalid", gpu_rvalid, 1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    model_reset();
    cpu_req = 1'b0; gpu_req = 1'b0;
    reset = 1'b1;
    repeat (8) step();
    cpu_pend = 1'b1; cpu_pend_addr = 13'h0010;
    drain(20);
    gpu_pend = 1'b1; gpu_pend_addr = 13'h0100; gpu_pend_len = 4'd3;
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
